// File: rtl/fifo_ctrl.sv
// fifo_ctrl -- pointer/flag controller for a FIFO built around an external RAM
// with a synchronous write port and an asynchronous read port.
//
// The controller keeps (ADDR_WIDTH+1)-bit write/read pointers. The extra MSB
// lets the pointers wrap modulo 2*DEPTH, so the low ADDR_WIDTH bits feed the
// RAM directly and wrap DEPTH-1 -> 0 on their own. The head entry is always
// presented on read_addr (show-ahead), so RAM read data is valid whenever
// empty is low, and a pop simply consumes it.
//
// Ports
//   clk           : single clock, all state updates on its rising edge
//   rst           : synchronous active-high reset
//   push          : producer write request, sampled each cycle
//   pop           : consumer read request, sampled each cycle
//   clear_err     : synchronous clear of the sticky overflow/underflow flags
//   write_enable  : RAM write enable (= accepted push, combinational)
//   write_addr    : RAM write address (tail)
//   read_addr     : RAM asynchronous read address (head)
//   full, empty, almost_full, almost_empty : status flags
//   count         : stored-entry count, 0..DEPTH
//   overflow      : sticky, set after a rejected push
//   underflow     : sticky, set after a rejected pop
module fifo_ctrl #(
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned AFULL_LEVEL  = (2 ** ADDR_WIDTH) - 2,
  parameter int unsigned AEMPTY_LEVEL = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clear_err,
  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [ADDR_WIDTH-1:0] read_addr,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AFULL_C  = AFULL_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = AEMPTY_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] ONE_C    = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0] count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                udf_q, udf_d;
  logic                push_acc;
  logic                pop_acc;

  // Flags come only from registered count, so accept decisions never depend
  // on this cycle's requests (no bypass from push to pop when empty).
  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign almost_full  = (count_q >= AFULL_C);
  assign almost_empty = (count_q <= AEMPTY_C);

  assign push_acc = push & ~full;
  assign pop_acc  = pop & ~empty;

  assign write_enable = push_acc;
  assign write_addr   = wptr_q[ADDR_WIDTH-1:0];
  assign read_addr    = rptr_q[ADDR_WIDTH-1:0];
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_acc) wptr_d = wptr_q + ONE_C;
    if (pop_acc)  rptr_d = rptr_q + ONE_C;
    unique case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
    // A new error in the same cycle as clear_err keeps the flag set.
    ovf_d = (push & full)  | (ovf_q & ~clear_err);
    udf_d = (pop  & empty) | (udf_q & ~clear_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed testbench for fifo_ctrl (ADDR_WIDTH=4, DEPTH=16, AFULL=14, AEMPTY=2).
// A small behavioural RAM sits beside the controller so head data can be
// checked against the values the bench pushed.
module tb_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst, push, pop, clear_err;
  logic       write_enable;
  logic [3:0] write_addr, read_addr;
  logic       full, empty, almost_full, almost_empty;
  logic [4:0] count;
  logic       overflow, underflow;

  logic [7:0] din;
  logic [7:0] mem [16];
  logic       we_seen;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  fifo_ctrl #(
    .ADDR_WIDTH  (4),
    .AFULL_LEVEL (14),
    .AEMPTY_LEVEL(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .pop         (pop),
    .clear_err   (clear_err),
    .write_enable(write_enable),
    .write_addr  (write_addr),
    .read_addr   (read_addr),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always @(posedge clk) begin
    if (write_enable) mem[write_addr] <= din;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, note write_enable before the edge, then sample
  // registered state 1ns after the edge and return inputs to idle.
  task automatic cyc(input logic p, input logic q, input logic c, input logic r,
                     input logic [7:0] d);
    push = p; pop = q; clear_err = c; rst = r; din = d;
    #1 we_seen = write_enable;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; clear_err = 1'b0; rst = 1'b0;
  endtask

  initial begin
    logic [3:0] prev_ra;
    int unsigned wraps;
    push = 0; pop = 0; clear_err = 0; rst = 1; din = '0;
    @(negedge clk);
    cyc(0, 0, 0, 1, 8'h00);
    cyc(0, 0, 0, 1, 8'h00);

    // Reset state
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_aempty", almost_empty, 1);
    check("rst_full", full, 0);
    check("rst_afull", almost_full, 0);
    check("rst_waddr", write_addr, 0);
    check("rst_raddr", read_addr, 0);
    check("rst_ovf", overflow, 0);
    check("rst_udf", underflow, 0);
    check("rst_we_idle", write_enable, 0);
    push = 1; #1;
    check("rst_we_push", write_enable, 1);
    push = 0; #1;

    // Fill with 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      cyc(1, 0, 0, 0, 8'(i));
      check("fill_we", we_seen, 1);
      check("fill_count", count, i + 1);
      check("fill_afull", almost_full, (i + 1) >= 14);
      check("fill_aempty", almost_empty, (i + 1) <= 2);
      check("fill_full", full, (i == 15));
    end
    check("fill_waddr_wrap", write_addr, 0);

    // Drain, head data in order
    for (int i = 0; i < 16; i++) begin
      check("drain_empty", empty, 0);
      check("drain_head", mem[read_addr], i);
      cyc(0, 1, 0, 0, 8'h00);
      check("drain_count", count, 15 - i);
    end
    check("drain_empty_end", empty, 1);
    check("drain_raddr", read_addr, 0);
    check("drain_udf", underflow, 0);

    // Full + push + pop: push rejected, pop accepted
    for (int i = 0; i < 16; i++) cyc(1, 0, 0, 0, 8'(8'h20 + i));
    check("full2", full, 1);
    cyc(1, 1, 0, 0, 8'hEE);
    check("fpp_we", we_seen, 0);
    check("fpp_count", count, 15);
    check("fpp_ovf", overflow, 1);
    check("fpp_raddr", read_addr, 1);
    check("fpp_head", mem[read_addr], 8'h21);
    check("fpp_udf", underflow, 0);

    // Sticky overflow clear behaviour
    cyc(0, 0, 1, 0, 8'h00);
    check("ovf_clr", overflow, 0);
    cyc(1, 0, 0, 0, 8'h30);
    check("refull", full, 1);
    cyc(1, 0, 0, 0, 8'hEF);
    check("ovf_set", overflow, 1);
    check("ovf_count", count, 16);
    cyc(1, 0, 1, 0, 8'hEF);
    check("ovf_clr_vs_err", overflow, 1);
    cyc(0, 0, 1, 0, 8'h00);
    check("ovf_clr2", overflow, 0);

    for (int i = 0; i < 16; i++) begin
      check("drain2_head", mem[read_addr], (i < 15) ? (8'h21 + i) : 8'h30);
      cyc(0, 1, 0, 0, 8'h00);
    end
    check("drain2_empty", empty, 1);

    // Empty + push + pop: pop rejected, push accepted, no bypass
    cyc(1, 1, 0, 0, 8'h55);
    check("epp_we", we_seen, 1);
    check("epp_count", count, 1);
    check("epp_udf", underflow, 1);
    check("epp_empty", empty, 0);
    check("epp_head", mem[read_addr], 8'h55);
    cyc(0, 0, 1, 0, 8'h00);
    check("udf_clr", underflow, 0);
    cyc(0, 1, 0, 0, 8'h00);
    check("udf_none", underflow, 0);
    cyc(0, 1, 1, 0, 8'h00);
    check("udf_clr_vs_err", underflow, 1);
    cyc(0, 0, 1, 0, 8'h00);
    check("udf_clr2", underflow, 0);

    // Steady push+pop at count 5 for 40 cycles
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 8'(8'h60 + i));
    check("ss_start", count, 5);
    wraps = 0;
    for (int i = 0; i < 40; i++) begin
      check("ss_head", mem[read_addr], 8'h60 + i);
      prev_ra = read_addr;
      cyc(1, 1, 0, 0, 8'(8'h65 + i));
      if (prev_ra == 4'd15 && read_addr == 4'd0) wraps++;
      check("ss_count", count, 5);
    end
    check("ss_wraps", wraps >= 2, 1);
    check("ss_head_end", mem[read_addr], 8'h88);

    // Reset mid-operation with push asserted
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 8'(8'h90 + i));
    check("pre_rst_count", count, 9);
    cyc(1, 0, 0, 1, 8'hAA);
    check("mrst_count", count, 0);
    check("mrst_empty", empty, 1);
    check("mrst_aempty", almost_empty, 1);
    check("mrst_full", full, 0);
    check("mrst_waddr", write_addr, 0);
    check("mrst_raddr", read_addr, 0);
    check("mrst_ovf", overflow, 0);
    check("mrst_udf", underflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, SHALL set the RAM address width; depth DEPTH = 2**ADDR_WIDTH.
REQ-002 Parameter AFULL_LEVEL, default DEPTH-2, SHALL set the almost_full threshold.
REQ-003 Parameter AEMPTY_LEVEL, default 2, SHALL set the almost_empty threshold.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-006 push  input  1  SHALL be the write request from the producer, sampled each cycle.
REQ-007 pop  input  1  SHALL be the read request from the consumer, sampled each cycle.
REQ-008 clear_err  input  1  SHALL be a synchronous clear of the sticky error flags.
REQ-009 write_enable  output  1  SHALL drive the RAM write enable.
REQ-010 write_addr  output  ADDR_WIDTH  SHALL drive the RAM write address (tail).
REQ-011 read_addr  output  ADDR_WIDTH  SHALL drive the RAM asynchronous read address (head).
REQ-012 full, empty, almost_full, almost_empty  output  1 each  SHALL be the status flags.
REQ-013 count  output  ADDR_WIDTH+1  SHALL be the stored-entry count, 0..DEPTH.
REQ-014 overflow, underflow  output  1 each  SHALL be the sticky error flags.

Function
REQ-015 Write and read pointers SHALL be ADDR_WIDTH+1 bits; write_addr/read_addr SHALL be their low ADDR_WIDTH bits.
REQ-016 Push accept SHALL be push & !full; pop accept SHALL be pop & !empty; both evaluated on current-cycle registered state.
REQ-017 write_enable SHALL equal push accept combinationally, so the RAM captures data at write_addr on the same edge.
REQ-018 On push accept the write pointer SHALL increment by 1 at the edge; on pop accept the read pointer SHALL increment by 1.
REQ-019 Pointers SHALL wrap modulo 2*DEPTH; address wrap DEPTH-1 -> 0 SHALL need no special handling.
REQ-020 read_addr SHALL always present the head entry (show-ahead): RAM data_out is valid whenever empty=0, with zero-cycle read latency; pop consumes it.
REQ-021 count SHALL be a register: +1 on push-only accept, -1 on pop-only accept, unchanged on both or neither.
REQ-022 empty = (count==0); full = (count==DEPTH); almost_full = (count>=AFULL_LEVEL); almost_empty = (count<=AEMPTY_LEVEL); all combinational from registered state.
REQ-023 Push while full SHALL be rejected (no write_enable, no pointer move) even if pop is asserted that cycle; the pop SHALL still be accepted.
REQ-024 Pop while empty SHALL be rejected even if push is asserted that cycle (no bypass); the push SHALL still be accepted.
REQ-025 overflow SHALL set on the edge after any rejected push; underflow SHALL set on the edge after any rejected pop.
REQ-026 Sticky flags SHALL hold until clear_err or rst; a new error in the same cycle as clear_err SHALL win (flag stays 1).
REQ-027 Simultaneous push and pop accept with 0<count<DEPTH SHALL move both pointers and keep count unchanged.

Reset
REQ-028 When rst=1 at an edge, pointers, count, overflow, underflow SHALL become 0, overriding push/pop/clear_err.
REQ-029 After reset: empty=1, almost_empty=1, full=0, almost_full=0, write_addr=0, read_addr=0, write_enable=push.
REQ-030 Reset mid-operation SHALL discard all stored entries; RAM contents SHALL not be cleared and SHALL not be read as valid.

Verification (ADDR_WIDTH=4, DEPTH=16, AFULL_LEVEL=14, AEMPTY_LEVEL=2)
REQ-031 Reset then 16 pushes of 0x00..0x0F -> count 16, full=1, almost_full from count 14, write_addr back at 0; then 16 pops -> head data 0x00..0x0F in order, empty=1.
REQ-032 Full, push=1 pop=1 one cycle -> write_enable=0, count 15, overflow=1 next cycle, read_addr advanced by 1.
REQ-033 Empty, push=1 pop=1 one cycle -> write_enable=1, count 1, underflow=1, empty=0 next cycle, head data = pushed value.
REQ-034 Continuous push+pop for 40 cycles at count 5 -> count stays 5, addresses wrap 15->0 twice, data order preserved.
REQ-035 overflow=1, assert clear_err with no push -> overflow=0 next cycle; clear_err with rejected push same cycle -> overflow stays 1.
REQ-036 count 9, rst=1 with push=1 -> next cycle count 0, empty=1, both addresses 0, no flags set.
